ysyx_22041071_id_opnd: RTL and testbench
========================================

Name: ysyx_22041071_id_opnd

Overview:
Parametrised decode-side operand stage for the in-order RISC-V pipeline. It holds the XLEN x NREG register file and resolves source operands through EX, MEM and WB bypasses. A per-register scoreboard tracks long-latency writers (loads), so variable-latency memory cannot cause RAW hazards. Operands reach EX through a valid/ready output register, with flush support.

Parameters:
XLEN, 64, datapath and register width
NREG, 32, architectural register count; AW = clog2(NREG)
SBW, 2, scoreboard counter width; at most 2^SBW-1 outstanding long writes per register

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage accepts instruction
in_pc  in  XLEN  instruction PC
in_rs1 / in_rs2 / in_rd  in  AW  register indices
in_rs1_en / in_rs2_en / in_rd_en  in  1  index used
in_long  in  1  result arrives at WB only (load)
in_src1_pc  in  1  src_a = PC instead of rs1
in_src2_imm  in  1  src_b = imm instead of rs2
in_imm  in  XLEN  sign-extended immediate
ex_fwd_data  in  XLEN  combinational EX result of the instruction in this block's output register
mem_fwd_valid  in  1  non-long result in MEM
mem_fwd_rd  in  AW  MEM destination
mem_fwd_data  in  XLEN  MEM result
wb_en  in  1  register write
wb_rd  in  AW  write index
wb_data  in  XLEN  write data
wb_long  in  1  write retires a long op
flush  in  1  kill output register (redirect)
out_valid  out  1  operands valid
out_ready  in  1  EX accepts
out_pc  out  XLEN  registered PC
out_rd  out  AW  registered destination
out_rd_en  out  1  registered rd enable
out_long  out  1  registered long flag
out_src_a / out_src_b  out  XLEN  ALU operands
out_rs2_data  out  XLEN  store data
dbg_addr  in  AW  difftest read index
dbg_data  out  XLEN  register file read (x0 = 0)

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers and scoreboard counters go to 0.
  - All out_* outputs go to 0.
- Writes: on wb_en && wb_rd!=0, the register is written at posedge. x0 is never written.
- Source resolution for each enabled rs, in this priority:
  - rs==0 gives 0.
  - out_valid && out_rd_en && !out_long && out_rd==rs gives ex_fwd_data.
  - mem_fwd_valid && mem_fwd_rd==rs gives mem_fwd_data.
  - wb_en && wb_rd==rs gives wb_data (write-through).
  - Otherwise the register file value.
- hazard is asserted for an enabled rs!=0 when either holds:
  - Load-use: out_valid && out_rd_en && out_long && out_rd==rs.
  - Scoreboard: cnt[rs]!=0, except when cnt[rs]==1 && wb_en && wb_long && wb_rd==rs in the same cycle (resolved by the WB bypass).
- Saturation: hazard is also asserted when in_rd_en && in_long && cnt[in_rd] is at its maximum.
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Acceptance (in_valid && in_ready): next cycle out_* holds:
  - src_a = PC or the rs1 value.
  - src_b = imm or the rs2 value.
  - out_rs2_data = the rs2 value.
  - Latency is 1 cycle.
- Hold: out_valid && !out_ready holds every out_* stable. Upstream keeps ex_fwd valid while held.
- Drain: out_valid && out_ready && !accept clears out_valid.
- Scoreboard increment: on out_valid && out_ready && out_rd_en && out_long && out_rd!=0, cnt[out_rd]++.
- Scoreboard decrement: on wb_en && wb_long && wb_rd!=0, cnt[wb_rd]--.
- Same register incremented and decremented in one cycle: count unchanged. Decrement at 0 is illegal (assertion).
- Flush has priority over every out_* update:
  - out_valid <= 0 and nothing is accepted that cycle.
  - An out_ready handshake in the flush cycle still counts as issued (the scoreboard increments).
  - Flushed instructions never touch the scoreboard.

Test Plan:
- Reset mid-stream: out_valid=1, cnt[5]=2, reset low -> out_valid, dbg_data and all counters read 0 immediately (asynchronous).
- Bypass priority on rs1=7: x7=1; EX producer in output register with ex_fwd_data=2; mem_fwd rd7=3; wb rd7=4 -> out_src_a=2. Remove EX producer -> 3. Remove MEM -> 4. rs1=0 -> 0.
- Load-use, add rs1=9 behind a load writing x9:
  - Add is stalled (in_ready=0) while the load sits in the output register.
  - After issue, cnt[9]=1 and the add stays stalled until wb_long rd9 with data 0xAB.
  - In that same cycle in_ready=1 and the add captures 0xAB.
- Scoreboard depth: two loads to x3 issue -> cnt[3]=2. First wb_long does not release a consumer of x3; second does. A third load issues in the same cycle as a wb_long x3 -> cnt stays at its value.
- Saturation, SBW=2: three outstanding loads to x4 -> a fourth load to x4 sees in_ready=0 until one retires.
- Flush with a stalled output (out_ready=0) and a long op in the output register -> out_valid=0 next cycle, cnt unchanged, in_ready=0 during the flush cycle.

Source files
------------

// File: rtl/ysyx_22041071_id_opnd_if.sv
// Issue channel from the decode operand stage to EX.
// The master side is the operand stage's output register; the slave side is EX.
interface ysyx_22041071_id_opnd_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [AW-1:0]   out_rd;
    logic            out_rd_en;
    logic            out_long;
    logic [XLEN-1:0] out_src_a;
    logic [XLEN-1:0] out_src_b;
    logic [XLEN-1:0] out_rs2_data;

    modport master (
        output out_valid, out_pc, out_rd, out_rd_en, out_long,
               out_src_a, out_src_b, out_rs2_data,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pc, out_rd, out_rd_en, out_long,
               out_src_a, out_src_b, out_rs2_data,
        output out_ready
    );
endinterface

// File: rtl/ysyx_22041071_id_opnd.sv
// Decode operand stage: register file, EX/MEM/WB bypass, per-register load
// scoreboard and a valid/ready output register feeding EX.
module ysyx_22041071_id_opnd #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int SBW  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_rs1_en,
    input  logic            in_rs2_en,
    input  logic            in_rd_en,
    input  logic            in_long,
    input  logic            in_src1_pc,
    input  logic            in_src2_imm,
    input  logic [XLEN-1:0] in_imm,

    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            mem_fwd_valid,
    input  logic [AW-1:0]   mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,

    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_long,

    input  logic            flush,

    ysyx_22041071_id_opnd_if.master ex_if,

    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    typedef struct packed {
        logic [XLEN-1:0] val;
        logic            haz;
    } src_t;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [SBW-1:0]  cnt_q  [NREG];
    logic [SBW-1:0]  cnt_d  [NREG];

    logic            out_valid_q,    out_valid_d;
    logic [XLEN-1:0] out_pc_q,       out_pc_d;
    logic [AW-1:0]   out_rd_q,       out_rd_d;
    logic            out_rd_en_q,    out_rd_en_d;
    logic            out_long_q,     out_long_d;
    logic [XLEN-1:0] out_src_a_q,    out_src_a_d;
    logic [XLEN-1:0] out_src_b_q,    out_src_b_d;
    logic [XLEN-1:0] out_rs2_data_q, out_rs2_data_d;

    src_t src1, src2;
    logic hazard;
    logic accept;
    logic sb_inc;
    logic sb_dec;

    // Resolved value and hazard for one source index. A single outstanding
    // long write retiring this very cycle is covered by the WB bypass.
    function automatic src_t resolve(input logic [AW-1:0] rs, input logic en);
        src_t r;
        r.val = '0;
        r.haz = 1'b0;
        if (en && rs != '0) begin
            if (out_valid_q && out_rd_en_q && !out_long_q && out_rd_q == rs)
                r.val = ex_fwd_data;
            else if (mem_fwd_valid && mem_fwd_rd == rs)
                r.val = mem_fwd_data;
            else if (wb_en && wb_rd == rs)
                r.val = wb_data;
            else
                r.val = regs_q[rs];

            if (out_valid_q && out_rd_en_q && out_long_q && out_rd_q == rs)
                r.haz = 1'b1;
            if (cnt_q[rs] != '0 &&
                !(cnt_q[rs] == SBW'(1) && wb_en && wb_long && wb_rd == rs))
                r.haz = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        src1   = resolve(in_rs1, in_rs1_en);
        src2   = resolve(in_rs2, in_rs2_en);
        hazard = src1.haz || src2.haz ||
                 (in_rd_en && in_long && cnt_q[in_rd] == '1);
    end

    assign in_ready = !hazard && !flush && (!out_valid_q || ex_if.out_ready);
    assign accept   = in_valid && in_ready;
    assign sb_inc   = out_valid_q && ex_if.out_ready && out_rd_en_q &&
                      out_long_q && out_rd_q != '0;
    assign sb_dec   = wb_en && wb_long && wb_rd != '0;

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_rd != '0)
            regs_d[wb_rd] = wb_data;
    end

    // The issue handshake counts even when a flush lands in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sb_inc && out_rd_q == AW'(i))
                cnt_d[i] = cnt_d[i] + SBW'(1);
            if (sb_dec && wb_rd == AW'(i))
                cnt_d[i] = cnt_d[i] - SBW'(1);
        end
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_rd_d       = out_rd_q;
        out_rd_en_d    = out_rd_en_q;
        out_long_d     = out_long_q;
        out_src_a_d    = out_src_a_q;
        out_src_b_d    = out_src_b_q;
        out_rs2_data_d = out_rs2_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d    = 1'b1;
            out_pc_d       = in_pc;
            out_rd_d       = in_rd;
            out_rd_en_d    = in_rd_en;
            out_long_d     = in_long;
            out_src_a_d    = in_src1_pc ? in_pc : src1.val;
            out_src_b_d    = in_src2_imm ? in_imm : src2.val;
            out_rs2_data_d = src2.val;
        end else if (out_valid_q && ex_if.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_rd_q       <= '0;
            out_rd_en_q    <= 1'b0;
            out_long_q     <= 1'b0;
            out_src_a_q    <= '0;
            out_src_b_q    <= '0;
            out_rs2_data_q <= '0;
        end else begin
            regs_q         <= regs_d;
            cnt_q          <= cnt_d;
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_rd_q       <= out_rd_d;
            out_rd_en_q    <= out_rd_en_d;
            out_long_q     <= out_long_d;
            out_src_a_q    <= out_src_a_d;
            out_src_b_q    <= out_src_b_d;
            out_rs2_data_q <= out_rs2_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && sb_dec)
            assert (cnt_q[wb_rd] != '0);
    end

    assign ex_if.out_valid    = out_valid_q;
    assign ex_if.out_pc       = out_pc_q;
    assign ex_if.out_rd       = out_rd_q;
    assign ex_if.out_rd_en    = out_rd_en_q;
    assign ex_if.out_long     = out_long_q;
    assign ex_if.out_src_a    = out_src_a_q;
    assign ex_if.out_src_b    = out_src_b_q;
    assign ex_if.out_rs2_data = out_rs2_data_q;

    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_ysyx_22041071_id_opnd.sv
// Directed bench for the decode operand stage: bypass priority, load-use,
// scoreboard depth/saturation, flush and asynchronous reset.
module tb_ysyx_22041071_id_opnd;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int SBW  = 2;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_pc, in_imm;
    logic [AW-1:0]   in_rs1, in_rs2, in_rd;
    logic            in_rs1_en, in_rs2_en, in_rd_en, in_long, in_src1_pc, in_src2_imm;
    logic [XLEN-1:0] ex_fwd_data;
    logic            mem_fwd_valid;
    logic [AW-1:0]   mem_fwd_rd;
    logic [XLEN-1:0] mem_fwd_data;
    logic            wb_en, wb_long;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r2;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ysyx_22041071_id_opnd_if #(.XLEN(XLEN), .AW(AW)) ex_if ();

    ysyx_22041071_id_opnd #(.XLEN(XLEN), .NREG(NREG), .SBW(SBW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rd_en(in_rd_en),
        .in_long(in_long), .in_src1_pc(in_src1_pc), .in_src2_imm(in_src2_imm),
        .in_imm(in_imm), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .wb_long(wb_long),
        .flush(flush), .ex_if(ex_if), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] r2);
        exp_t e;
        e.pc = pc; e.a = a; e.b = b; e.r2 = r2;
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        total++;
        assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, 64'(ex_if.out_valid), 64'd1);
            chk({tag, "_pc"}, ex_if.out_pc, e.pc);
            chk({tag, "_src_a"}, ex_if.out_src_a, e.a);
            chk({tag, "_src_b"}, ex_if.out_src_b, e.b);
            chk({tag, "_rs2"}, ex_if.out_rs2_data, e.r2);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic insn(input logic [63:0] pc, input logic [4:0] rs1, input logic r1e,
                        input logic [4:0] rs2, input logic r2e, input logic [4:0] rd,
                        input logic rde, input logic lng, input logic s2imm,
                        input logic [63:0] imm);
        in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs1_en = r1e;
        in_rs2 = rs2; in_rs2_en = r2e; in_rd = rd; in_rd_en = rde;
        in_long = lng; in_src1_pc = 1'b0; in_src2_imm = s2imm; in_imm = imm;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_rs1_en = 1'b0; in_rs2_en = 1'b0; in_rd_en = 1'b0;
        in_long = 1'b0; in_src1_pc = 1'b0; in_src2_imm = 1'b0;
    endtask

    task automatic clr_side();
        mem_fwd_valid = 1'b0; wb_en = 1'b0; wb_long = 1'b0; flush = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [63:0] d, input logic lng);
        wb_en = 1'b1; wb_rd = rd; wb_data = d; wb_long = lng;
    endtask

    initial begin
        reset = 1'b0;
        in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        idle_in(); clr_side();
        mem_fwd_rd = '0; mem_fwd_data = '0; wb_rd = '0; wb_data = '0;
        ex_fwd_data = 64'hEEEE; dbg_addr = '0; ex_if.out_ready = 1'b1;
        cyc(); cyc();
        chk("rst_valid", 64'(ex_if.out_valid), 64'd0);
        chk("rst_src_a", ex_if.out_src_a, 64'd0);
        chk("rst_cnt5", 64'(dut.cnt_q[5]), 64'd0);
        reset = 1'b1;

        // Register writes, x0 stays zero
        wb(7, 64'd1, 1'b0); cyc();
        wb(0, 64'hDEAD, 1'b0); cyc();
        clr_side(); dbg_addr = 7; #1;
        chk("dbg_x7", dbg_data, 64'd1);
        dbg_addr = 0; #1;
        chk("dbg_x0", dbg_data, 64'd0);

        // EX producer P writing x7, held one cycle
        insn(64'h100, 0, 0, 0, 0, 7, 1, 0, 1, 64'h55); #1;
        chk("p_rdy", 64'(in_ready), 64'd1);
        push_exp(64'h100, 0, 64'h55, 0);
        cyc();
        idle_in(); ex_if.out_ready = 1'b0; #1;
        check_out("p");
        chk("hold_rdy", 64'(in_ready), 64'd0);
        cyc();
        chk("hold_pc", ex_if.out_pc, 64'h100);

        // C1: EX beats MEM beats WB
        ex_if.out_ready = 1'b1; ex_fwd_data = 64'd2;
        mem_fwd_valid = 1'b1; mem_fwd_rd = 7; mem_fwd_data = 64'd3;
        wb(7, 64'd4, 1'b0);
        insn(64'h200, 7, 1, 0, 0, 0, 0, 0, 1, 64'h10); #1;
        chk("c1_rdy", 64'(in_ready), 64'd1);
        push_exp(64'h200, 64'd2, 64'h10, 0);
        cyc();
        // C2: MEM beats WB
        ex_fwd_data = 64'hEEEE;
        insn(64'h204, 7, 1, 0, 0, 0, 0, 0, 1, 64'h20); #1;
        check_out("c1");
        push_exp(64'h204, 64'd3, 64'h20, 0);
        cyc();
        // C3: WB write-through over register value 4
        mem_fwd_valid = 1'b0; wb(7, 64'd6, 1'b0);
        insn(64'h208, 7, 1, 0, 0, 0, 0, 0, 1, 64'h30); #1;
        check_out("c2");
        push_exp(64'h208, 64'd6, 64'h30, 0);
        cyc();
        // C4: rs1=x0 ignores MEM rd0; rs2 from register file
        wb_en = 1'b0; mem_fwd_valid = 1'b1; mem_fwd_rd = 0; mem_fwd_data = 64'd9;
        insn(64'h20C, 0, 1, 7, 1, 0, 0, 0, 0, 64'h99); #1;
        check_out("c3");
        push_exp(64'h20C, 0, 64'd6, 64'd6);
        cyc();
        clr_side(); idle_in(); #1;
        check_out("c4");
        cyc();
        chk("drain_valid", 64'(ex_if.out_valid), 64'd0);

        // Load-use on x9
        insn(64'h300, 0, 0, 0, 0, 9, 1, 1, 1, 0);
        push_exp(64'h300, 0, 0, 0);
        cyc();
        ex_if.out_ready = 1'b0;
        insn(64'h304, 9, 1, 7, 1, 10, 1, 0, 0, 0); #1;
        chk("lu_hold", 64'(in_ready), 64'd0);
        check_out("ld9");
        cyc();
        ex_if.out_ready = 1'b1; #1;
        chk("lu_issue", 64'(in_ready), 64'd0);
        cyc();
        chk("lu_cnt1", 64'(dut.cnt_q[9]), 64'd1);
        chk("lu_sb", 64'(in_ready), 64'd0);
        cyc();
        chk("lu_sb2", 64'(in_ready), 64'd0);
        wb(9, 64'hAB, 1'b1); #1;
        chk("lu_wb", 64'(in_ready), 64'd1);
        push_exp(64'h304, 64'hAB, 64'd6, 64'd6);
        cyc();
        clr_side(); idle_in(); #1;
        chk("lu_cnt0", 64'(dut.cnt_q[9]), 64'd0);
        check_out("add");
        cyc();

        // Scoreboard depth on x3
        insn(64'h400, 0, 0, 0, 0, 3, 1, 1, 1, 0);
        push_exp(64'h400, 0, 0, 0);
        cyc();
        insn(64'h404, 0, 0, 0, 0, 3, 1, 1, 1, 0); #1;
        check_out("l1");
        push_exp(64'h404, 0, 0, 0);
        cyc();
        idle_in(); #1;
        check_out("l2");
        cyc();
        chk("sb_cnt2", 64'(dut.cnt_q[3]), 64'd2);
        insn(64'h408, 3, 1, 0, 0, 11, 1, 0, 1, 64'd1);
        wb(3, 64'h11, 1'b1); #1;
        chk("sb_wb1", 64'(in_ready), 64'd0);
        cyc();
        clr_side();
        insn(64'h40C, 0, 0, 0, 0, 3, 1, 1, 1, 0);
        push_exp(64'h40C, 0, 0, 0);
        cyc();
        wb(3, 64'h22, 1'b1);
        insn(64'h408, 3, 1, 0, 0, 11, 1, 0, 1, 64'd1); #1;
        chk("sb_lu", 64'(in_ready), 64'd0);
        check_out("l3");
        cyc();
        chk("sb_same", 64'(dut.cnt_q[3]), 64'd1);
        wb(3, 64'h33, 1'b1); #1;
        chk("sb_rel", 64'(in_ready), 64'd1);
        push_exp(64'h408, 64'h33, 64'd1, 0);
        cyc();
        clr_side(); idle_in(); #1;
        chk("sb_cnt0", 64'(dut.cnt_q[3]), 64'd0);
        check_out("b");
        cyc();

        // Saturation on x4
        insn(64'h500, 0, 0, 0, 0, 4, 1, 1, 1, 0);
        push_exp(64'h500, 0, 0, 0);
        cyc();
        insn(64'h504, 0, 0, 0, 0, 4, 1, 1, 1, 0); #1;
        check_out("la");
        push_exp(64'h504, 0, 0, 0);
        cyc();
        insn(64'h508, 0, 0, 0, 0, 4, 1, 1, 1, 0); #1;
        check_out("lb");
        push_exp(64'h508, 0, 0, 0);
        cyc();
        idle_in(); #1;
        check_out("lc");
        cyc();
        chk("sat_cnt3", 64'(dut.cnt_q[4]), 64'd3);
        insn(64'h50C, 0, 0, 0, 0, 4, 1, 1, 1, 0); #1;
        chk("sat_block", 64'(in_ready), 64'd0);
        cyc();
        chk("sat_block2", 64'(in_ready), 64'd0);
        wb(4, 64'h44, 1'b1); #1;
        chk("sat_wb", 64'(in_ready), 64'd0);
        cyc();
        clr_side(); #1;
        chk("sat_free", 64'(in_ready), 64'd1);
        push_exp(64'h50C, 0, 0, 0);
        cyc();

        // Flush with a stalled long op in the output register
        idle_in(); ex_if.out_ready = 1'b0; #1;
        check_out("ld");
        chk("fl_cnt_pre", 64'(dut.cnt_q[4]), 64'd2);
        flush = 1'b1;
        insn(64'h600, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("fl_rdy", 64'(in_ready), 64'd0);
        cyc();
        flush = 1'b0; idle_in(); #1;
        chk("fl_valid", 64'(ex_if.out_valid), 64'd0);
        chk("fl_cnt", 64'(dut.cnt_q[4]), 64'd2);
        ex_if.out_ready = 1'b1;

        // Asynchronous reset mid-stream with cnt[5]=2
        insn(64'h700, 0, 0, 0, 0, 5, 1, 1, 1, 0);
        push_exp(64'h700, 0, 0, 0);
        cyc();
        insn(64'h704, 0, 0, 0, 0, 5, 1, 1, 1, 0); #1;
        check_out("m1");
        push_exp(64'h704, 0, 0, 0);
        cyc();
        insn(64'h708, 0, 0, 0, 0, 0, 0, 0, 1, 64'h7);
        push_exp(64'h708, 0, 64'h7, 0); #1;
        check_out("m2");
        cyc();
        idle_in(); ex_if.out_ready = 1'b0; dbg_addr = 3; #1;
        chk("mr_cnt5", 64'(dut.cnt_q[5]), 64'd2);
        check_out("n");
        chk("mr_dbg3", dbg_data, 64'h33);
        #1 reset = 1'b0;
        #1;
        chk("ar_valid", 64'(ex_if.out_valid), 64'd0);
        chk("ar_dbg3", dbg_data, 64'd0);
        chk("ar_cnt5", 64'(dut.cnt_q[5]), 64'd0);
        chk("ar_cnt4", 64'(dut.cnt_q[4]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
